// File: rtl/branch_predictor_btb_if.sv
// IF-stage lookup, EX-stage training and invalidate signals of the branch target buffer.
// Statistics signals exist only when BP_STATS_EN is defined.
interface branch_predictor_btb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_jump;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            inv_req;
  logic            busy;
`ifdef BP_STATS_EN
  logic            lookup_valid;
  logic            upd_mispredict;
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, inv_req,
           lookup_valid, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, busy,
           stat_lookups, stat_hits, stat_mispredicts
  );
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, inv_req,
           lookup_valid, upd_mispredict,
    output pred_hit, pred_taken, pred_target, busy,
           stat_lookups, stat_hits, stat_mispredicts
  );
`else
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, inv_req,
    input  pred_hit, pred_taken, pred_target, busy
  );
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target, inv_req,
    output pred_hit, pred_taken, pred_target, busy
  );
`endif
endinterface

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with saturating direction counters and a walking-invalidate FSM.
// Optional lookup/hit/mispredict statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 10,
  parameter int CNT_W   = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(2 ** (CNT_W - 1));

  // state | meaning
  // CLEAR | walking invalidate, one entry per cycle; predictions off, updates dropped
  // READY | predicting and training
  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             busy_q, busy_d;

  logic [ENTRIES-1:0]                  valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [ENTRIES-1:0][XLEN-1:0]        target_q, target_d;
  logic [ENTRIES-1:0][CNT_W-1:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, l_taken, u_hit, upd_en;

  assign l_idx = bus.lookup_pc[IDX_W+1:2];
  assign l_tag = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.lookup_pc[XLEN-1:IDX_W+TAG_W+2],
                            bus.upd_pc[1:0], bus.upd_pc[XLEN-1:IDX_W+TAG_W+2]};

  // Reads come from the current flops, so a same-cycle update is seen only next cycle.
  assign l_hit   = !busy_q && valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_taken = l_hit && cnt_q[l_idx][CNT_W-1];
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign bus.pred_hit    = l_hit;
  assign bus.pred_taken  = l_taken;
  assign bus.pred_target = l_taken ? target_q[l_idx] : '0;
  assign bus.busy        = busy_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    upd_en    = 1'b0;

    case (state_q)
      S_CLEAR: begin
        valid_d[clr_idx_q] = 1'b0;
        cnt_d[clr_idx_q]   = '0;
        if (bus.inv_req) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d   = S_READY;
          busy_d    = 1'b0;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      S_READY: begin
        if (bus.inv_req) begin
          state_d   = S_CLEAR;
          busy_d    = 1'b1;
          clr_idx_d = '0;
        end else begin
          upd_en = bus.upd_valid;
        end
      end
      default: begin
        state_d = S_CLEAR;
        busy_d  = 1'b1;
      end
    endcase

    if (upd_en) begin
      if (u_hit) begin
        if (bus.upd_is_jump) begin
          cnt_d[u_idx]    = CNT_MAX;
          target_d[u_idx] = bus.upd_target;
        end else if (bus.upd_taken) begin
          if (cnt_q[u_idx] != CNT_MAX) cnt_d[u_idx] = cnt_q[u_idx] + CNT_W'(1);
          target_d[u_idx] = bus.upd_target;
        end else if (cnt_q[u_idx] != '0) begin
          cnt_d[u_idx] = cnt_q[u_idx] - CNT_W'(1);
        end
      end else if (bus.upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bus.upd_target;
        cnt_d[u_idx]    = bus.upd_is_jump ? CNT_MAX : CNT_WEAK;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_lookups_d     = stat_lookups_q + 32'(bus.lookup_valid && !busy_q);
    stat_hits_d        = stat_hits_q + 32'(bus.lookup_valid && l_hit);
    stat_mispredicts_d = stat_mispredicts_q +
                         32'(bus.upd_valid && bus.upd_mispredict && (state_q == S_READY));
  end

  assign bus.stat_lookups     = stat_lookups_q;
  assign bus.stat_hits        = stat_hits_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_hits_q        <= stat_hits_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end
`endif

  // Table contents are not reset here; the CLEAR walk that follows reset invalidates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomized + directed scoreboard bench for branch_predictor_btb against a table-level model.
module tb_branch_predictor_btb;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 10;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int CNT_MID = 1 << (CNT_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.XLEN(XLEN)) bus ();

  branch_predictor_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] target;
    bit          busy;
    logic [31:0] s_lookups;
    logic [31:0] s_hits;
    logic [31:0] s_mis;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the table as plain arrays, busy as a count of remaining busy cycles.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  int          m_cnt   [ENTRIES];
  int          busy_left;
  logic [31:0] m_lookups, m_hits, m_mis;

  int tests  = 0;
  int errors = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
  endfunction

  function automatic void model_invalidate();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  task automatic cycle(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit uj, input bit ut, input logic [31:0] utgt,
                       input bit inv, input bit r, input bit lv, input bit mp);
    exp_t e;
    int   li, ui;
    bit   uhit;
    rst             = r;
    bus.lookup_pc   = lpc;
    bus.upd_valid   = uv;
    bus.upd_pc      = upc;
    bus.upd_is_jump = uj;
    bus.upd_taken   = ut;
    bus.upd_target  = utgt;
    bus.inv_req     = inv;
`ifdef BP_STATS_EN
    bus.lookup_valid   = lv;
    bus.upd_mispredict = mp;
`endif
    li          = idx_of(lpc);
    e.busy      = (busy_left > 0);
    e.hit       = !e.busy && m_valid[li] && (m_tag[li] == tag_of(lpc));
    e.taken     = e.hit && (m_cnt[li] >= CNT_MID);
    e.target    = e.taken ? m_target[li] : 32'h0;
    e.s_lookups = m_lookups;
    e.s_hits    = m_hits;
    e.s_mis     = m_mis;
    exp_q.push_back(e);

    @(posedge clk);
    if (r) begin
      busy_left = ENTRIES;
      model_invalidate();
      m_lookups = 0;
      m_hits    = 0;
      m_mis     = 0;
    end else begin
      if (lv && !e.busy) m_lookups++;
      if (lv && e.hit) m_hits++;
      if (uv && mp && !e.busy) m_mis++;
      if (inv) begin
        busy_left = ENTRIES;
        model_invalidate();
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (uv) begin
        ui   = idx_of(upc);
        uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
        if (uhit) begin
          if (uj) begin
            m_cnt[ui]    = CNT_MAX;
            m_target[ui] = utgt;
          end else if (ut) begin
            if (m_cnt[ui] < CNT_MAX) m_cnt[ui]++;
            m_target[ui] = utgt;
          end else if (m_cnt[ui] > 0) begin
            m_cnt[ui]--;
          end
        end else if (ut) begin
          m_valid[ui]  = 1'b1;
          m_tag[ui]    = tag_of(upc);
          m_target[ui] = utgt;
          m_cnt[ui]    = uj ? CNT_MAX : CNT_MID;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(lpc, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 0);
  endtask

  task automatic upd(input logic [31:0] lpc, input logic [31:0] upc, input bit uj,
                     input bit ut, input logic [31:0] utgt);
    cycle(lpc, 1, upc, uj, ut, utgt, 0, 0, 1, 0);
  endtask

  // Monitor: the outputs are presented every cycle; compare mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy", 32'(bus.busy), 32'(e.busy));
        check("pred_hit", 32'(bus.pred_hit), 32'(e.hit));
        check("pred_taken", 32'(bus.pred_taken), 32'(e.taken));
        check("pred_target", bus.pred_target, e.target);
`ifdef BP_STATS_EN
        check("stat_lookups", bus.stat_lookups, e.s_lookups);
        check("stat_hits", bus.stat_hits, e.s_hits);
        check("stat_mispredicts", bus.stat_mispredicts, e.s_mis);
`endif
      end
    end
  end

  initial begin
    logic [31:0] lpc, upc, tgt;
    bit          uj, ut;
    bus.lookup_pc   = '0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = '0;
    bus.upd_is_jump = 1'b0;
    bus.upd_taken   = 1'b0;
    bus.upd_target  = '0;
    bus.inv_req     = 1'b0;
`ifdef BP_STATS_EN
    bus.lookup_valid   = 1'b0;
    bus.upd_mispredict = 1'b0;
`endif
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 0;
    end
    m_lookups = 0; m_hits = 0; m_mis = 0;

    // First reset edge establishes a known state; checking starts with the second.
    rst = 1'b1;
    @(posedge clk);
    busy_left = ENTRIES;
    #1;
    cycle(32'h40, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 0);

    // CLEAR window: lookups miss and updates are dropped.
    for (int i = 0; i < ENTRIES; i++)
      cycle($urandom & 32'hFF, 1, 32'h40, 0, 1, 32'h80, 0, 0, 1, 1);
    idle(32'h40);

    // Allocation of a conditional branch, then hit/miss lookups.
    upd(32'h0, 32'h40, 0, 1, 32'h80);
    idle(32'h40);
    idle(32'h44);
    idle(32'h41);

    // Counter training down to saturation at zero, then up to the maximum.
    repeat (3) upd(32'h40, 32'h40, 0, 0, 32'h0);
    idle(32'h40);
    repeat (4) begin
      upd(32'h40, 32'h40, 0, 1, 32'h80);
    end
    idle(32'h40);

    // Tag conflict: a jump at the same index evicts the branch.
    upd(32'h0, 32'h80, 1, 1, 32'h100);
    idle(32'h40);
    idle(32'h80);

    // Same-cycle lookup and update: lookup sees the old counter.
    upd(32'h0, 32'h40, 0, 1, 32'h80);
    upd(32'h40, 32'h40, 0, 0, 32'h0);
    idle(32'h40);

    // Invalidate with a simultaneous update: invalidate wins.
    upd(32'h0, 32'h84, 1, 1, 32'h200);
    cycle(32'h84, 1, 32'h88, 1, 1, 32'h300, 1, 0, 1, 1);
    for (int i = 0; i < ENTRIES; i++) idle(32'h88);
    idle(32'h84);
    idle(32'h88);
    idle(32'h40);

    // inv_req during CLEAR restarts the walk; so does reset.
    cycle(32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 0);
    repeat (5) idle(32'h0);
    cycle(32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 0);
    repeat (5) idle(32'h0);
    cycle(32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 0);
    repeat (ENTRIES + 2) idle(32'h0);

    // Randomized traffic over a small PC pool so entries collide and retrain.
    repeat (800) begin
      lpc = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      uj  = ($urandom_range(0, 3) == 0);
      ut  = uj ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle(lpc, 1'($urandom_range(0, 1)), upc, uj, ut, tgt,
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
